// File: rtl/stream_merge_rr.sv
// stream_merge_rr: round-robin merge of two valid/ready streams into one
// ordered output stream through a small FIFO of {src, data} entries.
module stream_merge_rr #(
    parameter int unsigned D_WIDTH = 6,
    parameter int unsigned A_WIDTH = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid_a,
    output logic               in_ready_a,
    input  logic [D_WIDTH-1:0] in_data_a,
    input  logic               in_valid_b,
    output logic               in_ready_b,
    input  logic [D_WIDTH-1:0] in_data_b,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [D_WIDTH-1:0] out_data,
    output logic               out_src
);

    localparam int unsigned DEPTH   = 32'd1 << A_WIDTH;
    localparam int unsigned C_WIDTH = A_WIDTH + 1;

    typedef struct packed {
        logic               src;
        logic [D_WIDTH-1:0] data;
    } entry_t;

    entry_t               mem [DEPTH];
    logic [A_WIDTH-1:0]   wr_ptr;
    logic [A_WIDTH-1:0]   rd_ptr;
    logic [C_WIDTH-1:0]   count;
    logic                 last_src;

    logic                 full;
    logic                 empty;
    logic                 grant_a;
    logic                 grant_b;
    logic                 push;
    logic                 pop;
    entry_t               push_entry;
    entry_t               head;

    assign full  = (count == C_WIDTH'(DEPTH));
    assign empty = (count == '0);

    // Arbitration: single grant per cycle, ties go to the channel not served last
    always_comb begin
        grant_a = 1'b0;
        grant_b = 1'b0;
        if (!full) begin
            if (in_valid_a && !in_valid_b) begin
                grant_a = 1'b1;
            end else if (!in_valid_a && in_valid_b) begin
                grant_b = 1'b1;
            end else if (in_valid_a && in_valid_b) begin
                if (last_src) begin
                    grant_a = 1'b1;
                end else begin
                    grant_b = 1'b1;
                end
            end
        end
    end

    assign in_ready_a = grant_a;
    assign in_ready_b = grant_b;

    assign push = (in_valid_a & grant_a) | (in_valid_b & grant_b);
    assign pop  = out_valid & out_ready;

    // Entry written on a push carries the winning channel's payload and tag
    always_comb begin
        push_entry.src  = grant_b;
        push_entry.data = grant_b ? in_data_b : in_data_a;
    end

    assign head      = mem[rd_ptr];
    assign out_valid = !empty;
    assign out_data  = head.data;
    assign out_src   = head.src;

    // Storage array; contents survive reset, only the pointers are cleared
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= push_entry;
        end
    end

    // Pointers, occupancy and round-robin history
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            last_src <= 1'b1;
        end else begin
            if (push) begin
                wr_ptr   <= wr_ptr + A_WIDTH'(1);
                last_src <= grant_b;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + A_WIDTH'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + C_WIDTH'(1);
                2'b01:   count <= count - C_WIDTH'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_stream_merge_rr.sv
// Bench for stream_merge_rr: directed scenarios with literal expectations plus
// a queue-based reference model checked every cycle.
module tb_stream_merge_rr;

    localparam int unsigned DW    = 6;
    localparam int unsigned AW    = 2;
    localparam int unsigned DEPTH = 4;

    logic          clk;
    logic          rst;
    logic          in_valid_a;
    logic          in_ready_a;
    logic [DW-1:0] in_data_a;
    logic          in_valid_b;
    logic          in_ready_b;
    logic [DW-1:0] in_data_b;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic          out_src;

    int tests = 0;
    int fails = 0;

    stream_merge_rr #(.D_WIDTH(DW), .A_WIDTH(AW)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid_a (in_valid_a),
        .in_ready_a (in_ready_a),
        .in_data_a  (in_data_a),
        .in_valid_b (in_valid_b),
        .in_ready_b (in_ready_b),
        .in_data_b  (in_data_b),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_src    (out_src)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
        end
    endtask

    // Reference model: accepted words in arrival order, tagged with source
    logic [DW:0] mq[$];
    logic        m_last;
    logic        m_ga;
    logic        m_gb;
    logic [DW:0] m_head;

    // Compare DUT against the model mid-cycle, then advance the model
    always @(negedge clk) begin
        if (rst) begin
            mq.delete();
            m_last = 1'b1;
        end else begin
            m_ga = 1'b0;
            m_gb = 1'b0;
            if (mq.size() < DEPTH) begin
                if (in_valid_a && in_valid_b) begin
                    m_ga = (m_last == 1'b1);
                    m_gb = (m_last == 1'b0);
                end else begin
                    m_ga = in_valid_a;
                    m_gb = in_valid_b;
                end
            end
            check("ready_a", 32'(in_ready_a), 32'(m_ga));
            check("ready_b", 32'(in_ready_b), 32'(m_gb));
            check("one_ready", 32'(in_ready_a & in_ready_b), 32'd0);
            check("out_valid", 32'(out_valid), 32'(mq.size() != 0));
            if (mq.size() != 0) begin
                m_head = mq[0];
                check("out_data", 32'(out_data), 32'(m_head[DW-1:0]));
                check("out_src", 32'(out_src), 32'(m_head[DW]));
                if (out_ready) begin
                    void'(mq.pop_front());
                end
            end
            if (m_ga) begin
                mq.push_back({1'b0, in_data_a});
                m_last = 1'b0;
            end else if (m_gb) begin
                mq.push_back({1'b1, in_data_b});
                m_last = 1'b1;
            end
        end
    end

    // Apply one cycle of inputs shortly after the edge; return at mid-cycle
    task automatic drive(input logic r, input logic va, input logic [DW-1:0] da,
                         input logic vb, input logic [DW-1:0] db, input logic ordy);
        @(posedge clk);
        #1;
        rst        = r;
        in_valid_a = va;
        in_data_a  = da;
        in_valid_b = vb;
        in_data_b  = db;
        out_ready  = ordy;
        @(negedge clk);
    endtask

    task automatic idle(input logic ordy);
        drive(1'b0, 1'b0, DW'(0), 1'b0, DW'(0), ordy);
    endtask

    logic [DW-1:0] cur;

    initial begin
        rst        = 1'b1;
        in_valid_a = 1'b0;
        in_data_a  = '0;
        in_valid_b = 1'b0;
        in_data_b  = '0;
        out_ready  = 1'b0;

        drive(1'b1, 1'b0, DW'(0), 1'b0, DW'(0), 1'b0);
        drive(1'b1, 1'b0, DW'(0), 1'b0, DW'(0), 1'b0);

        // Post-reset idle state
        idle(1'b0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_ready_a", 32'(in_ready_a), 32'd0);
        check("rst_ready_b", 32'(in_ready_b), 32'd0);

        // Both channels valid: A wins first tie, then strict alternation
        for (int i = 0; i < 5; i++) begin
            drive(1'b0, 1'b1, DW'(8'h11), 1'b1, DW'(8'h22), 1'b1);
            if (i == 0) begin
                check("alt_first_valid", 32'(out_valid), 32'd0);
                check("alt_first_ready_a", 32'(in_ready_a), 32'd1);
            end else begin
                check("alt_data", 32'(out_data), (i % 2 == 1) ? 32'h11 : 32'h22);
                check("alt_src", 32'(out_src), (i % 2 == 1) ? 32'd0 : 32'd1);
            end
        end
        idle(1'b1);
        check("alt_tail_data", 32'(out_data), 32'h11);
        idle(1'b1);
        check("alt_empty", 32'(out_valid), 32'd0);

        // Only A valid, sink stalled: four accepted, then backpressure
        cur = DW'(1);
        for (int c = 0; c < 6; c++) begin
            drive(1'b0, 1'b1, cur, 1'b0, DW'(0), 1'b0);
            check("fill_ready_a", 32'(in_ready_a), (c < 4) ? 32'd1 : 32'd0);
            if (c == 4) begin
                check("fill_out_valid", 32'(out_valid), 32'd1);
                check("fill_head", 32'(out_data), 32'h01);
            end
            if (c < 4) cur = cur + DW'(1);
        end

        // Full with pop: no push this cycle, push accepted next cycle
        drive(1'b0, 1'b1, cur, 1'b0, DW'(0), 1'b1);
        check("full_pop_ready_a", 32'(in_ready_a), 32'd0);
        check("full_pop_head", 32'(out_data), 32'h01);
        drive(1'b0, 1'b1, cur, 1'b0, DW'(0), 1'b1);
        check("after_pop_ready_a", 32'(in_ready_a), 32'd1);
        check("after_pop_head", 32'(out_data), 32'h02);
        for (int k = 0; k < 3; k++) begin
            idle(1'b1);
            check("drain_data", 32'(out_data), 32'(3 + k));
        end
        idle(1'b1);
        check("drain_empty", 32'(out_valid), 32'd0);

        // Wrap: two B words fill slots 2,3, then push+pop at count 2 lands in slot 0
        drive(1'b0, 1'b0, DW'(0), 1'b1, DW'(8'h3A), 1'b0);
        check("wrap_ready_b0", 32'(in_ready_b), 32'd1);
        drive(1'b0, 1'b0, DW'(0), 1'b1, DW'(8'h3B), 1'b0);
        check("wrap_ready_b1", 32'(in_ready_b), 32'd1);
        drive(1'b0, 1'b0, DW'(0), 1'b1, DW'(8'h3F), 1'b1);
        check("wrap_pp_ready_b", 32'(in_ready_b), 32'd1);
        check("wrap_pp_head", 32'(out_data), 32'h3A);
        idle(1'b1);
        check("wrap_next", 32'(out_data), 32'h3B);
        check("wrap_next_src", 32'(out_src), 32'd1);
        idle(1'b1);
        check("wrap_last", 32'(out_data), 32'h3F);
        idle(1'b1);
        check("wrap_empty", 32'(out_valid), 32'd0);

        // Reset mid-operation discards stored words
        drive(1'b0, 1'b1, DW'(7), 1'b0, DW'(0), 1'b0);
        drive(1'b0, 1'b1, DW'(8), 1'b0, DW'(0), 1'b0);
        drive(1'b0, 1'b1, DW'(9), 1'b0, DW'(0), 1'b0);
        drive(1'b1, 1'b0, DW'(0), 1'b0, DW'(0), 1'b0);
        idle(1'b0);
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        drive(1'b0, 1'b1, DW'(8'h2A), 1'b0, DW'(0), 1'b0);
        check("midrst_ready_a", 32'(in_ready_a), 32'd1);
        idle(1'b1);
        check("midrst_first_valid", 32'(out_valid), 32'd1);
        check("midrst_first_data", 32'(out_data), 32'h2A);
        check("midrst_first_src", 32'(out_src), 32'd0);
        idle(1'b1);
        check("midrst_empty", 32'(out_valid), 32'd0);

        // Random traffic on both sides, model checks every cycle
        for (int n = 0; n < 1000; n++) begin
            drive(1'b0, 1'($urandom_range(0, 1)), DW'($urandom_range(0, 63)),
                  1'($urandom_range(0, 1)), DW'($urandom_range(0, 63)),
                  1'($urandom_range(0, 1)));
        end
        for (int n = 0; n < 6; n++) idle(1'b1);
        check("final_empty", 32'(out_valid), 32'd0);
        check("model_empty", 32'(mq.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
